stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  - Parametrised N-way, WIDTH-bit multiplexer with valid/ready handshake and registered output.
//  - Next generation of the datapath 4:1 select mux. Adds configurable channel count, a
//    round-robin arbitration mode alongside explicit select, a 1-entry output register
//    and a source tag.
//  - Merges request streams (e.g. memory-port clients) into one consumer.
// PARAMETERS
//  WIDTH   32             data bits per channel
//  N       4              number of input channels, 2..16
//  SELW    $clog2(N)      select/tag width (derived; do not override)
//  MODE    0              0 = SELECT (sel port chooses channel), 1 = ROUND_ROBIN arbitration
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_data    in   N*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N         per-channel valid
//  in_ready   out  N         per-channel ready; at most one bit high per cycle
//  sel        in   SELW      channel select, used only when MODE=0
//  out_data   out  WIDTH     registered data
//  out_src    out  SELW      index of the channel that supplied out_data
//  out_valid  out  1         output register holds a beat
//  out_ready  in   1         consumer accepts the beat
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr pointer=0.
//    Assert mid-transfer: beat discarded, no in_ready pulse in that cycle.
//  - can_load = !out_valid || out_ready. Full throughput, 1 beat/cycle.
//  - Grant g, one-hot:
//    - MODE 0: g[sel] = in_valid[sel]; sel >= N gives g = 0 (no channel).
//    - MODE 1: first valid channel at or after ptr, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - in_ready = g & {N{can_load}}, combinational from in_valid/sel/ptr/out_valid/out_ready.
//  - Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge: out_data = channel i
//    data, out_src = i, out_valid = 1. Latency is 1 cycle, input handshake to out_valid.
//  - out_valid && !out_ready: out_data/out_src/out_valid held stable. Changes to sel/in_* ignored.
//  - out_valid && out_ready with no new transfer: out_valid -> 0; out_data/out_src hold last value.
//  - Simultaneous drain and load: the new beat replaces the old in the same edge, no bubble.
//  - RR pointer: after a transfer from channel i, ptr = (i == N-1) ? 0 : i+1.
//    Unchanged when no transfer occurs. Unused when MODE=0.
//  - No valid inputs: g = 0; register drains normally.
//  - Upstream contract: valid must not drop before handshake. Bench asserts this, and that
//    $onehot0(in_ready) holds.
//  - Arithmetic: pointer wrap uses explicit compare against N-1. No reliance on power-of-2 N.
// STRUCTURE
//  - Shared package mux_pkg: localparams MODE_SELECT=0, MODE_RR=1; function clog2 for SELW.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr, advance; outputs grant[N] (one-hot)
//    and grant_idx[SELW]; owns the ptr register and its reset.
//  - Top: grant mux (MODE generate), WIDTH-bit one-hot data select (AND-OR), output register.
// TESTING
//  1. Reset mid-stall: MODE0, out_valid=1, out_ready=0; assert rst_n=0 -> out_valid=0
//     immediately, in_ready=0 during reset, ptr=0 after release.
//  2. Select path: MODE0, N=4, sel=2, in_valid=4'b0100, data2=32'hDEADBEEF, out_ready=1
//     -> next cycle out_data=DEADBEEF, out_src=2. sel=5 (N=5): in_ready=0.
//  3. Backpressure: out_ready=0 for 3 cycles after a load -> out_data stable, in_ready=0,
//     then out_ready=1 -> back-to-back beats, no bubble.
//  4. Round-robin fairness: MODE1, all 4 valid continuously, out_ready=1
//     -> out_src sequence 0,1,2,3,0,1... Only ch3 valid after ptr=1 -> grant 3, ptr wraps to 0.
//  5. Non-power-of-2: N=3, MODE1, valid=3'b101 -> out_src 0,2,0,2. ptr never indexes ch3.
//  6. Random stress: random in_valid/out_ready, 10k cycles; scoreboard checks per-channel order,
//     no loss/duplication, onehot0(in_ready).

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the stream mux slice
package mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Ceiling log2, used to size select/tag fields from the channel count
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter owning its rotating priority pointer
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic [SELW:0]   cand;
  logic            found;

  // Search ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the wrap is an explicit compare so any N works
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
      if (!found && req[cand[SELW-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SELW-1:0]]   = 1'b1;
        grant_idx               = cand[SELW-1:0];
      end
    end
  end

  // Next pointer: one past the channel that just transferred, wrapping at N-1
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
    end
  end

  // Pointer register; moves only when a beat is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-way valid/ready stream mux with select or round-robin grant and registered output
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2(N),
  parameter int MODE  = MODE_SELECT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;

  logic             active_q;
  logic             active_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic [SELW-1:0]  out_src_q;
  logic [SELW-1:0]  out_src_d;

  // The output register can take a beat when empty or when its beat leaves this cycle.
  // active_q keeps in_ready low while reset is asserted, so an aborted beat never handshakes.
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = grant & {N{can_load && active_q}};
  assign xfer     = |in_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;

      rr_arbiter #(
        .N    (N),
        .SELW (SELW)
      ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
      );
    end else begin : g_select
      logic sel_in_range;
      assign sel_in_range = ({1'b0, sel} < (SELW+1)'(N));
      assign grant_idx    = sel;

      // Explicit select: out-of-range sel grants nothing
      always_comb begin
        grant = '0;
        if (sel_in_range) begin
          grant[sel] = in_valid[sel];
        end
      end
    end
  endgenerate

  // One-hot AND-OR data select; no priority chain on the datapath
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < N; i++) begin
      beat_data = beat_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Output register next state: load replaces any draining beat, otherwise drain or hold
  always_comb begin
    active_d    = 1'b1;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_src_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and post-reset enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr in select and round-robin modes
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: N=4 select, dut1: N=4 round-robin, dut2: N=3 round-robin, dut3: N=5 select
  logic [127:0] d0_in_data = '0;
  logic [3:0]   d0_in_valid = '0;
  logic [3:0]   d0_in_ready;
  logic [1:0]   d0_sel = '0;
  logic [31:0]  d0_out_data;
  logic [1:0]   d0_out_src;
  logic         d0_out_valid;
  logic         d0_out_ready = 1'b0;

  logic [127:0] d1_in_data = '0;
  logic [3:0]   d1_in_valid = '0;
  logic [3:0]   d1_in_ready;
  logic [1:0]   d1_sel = '0;
  logic [31:0]  d1_out_data;
  logic [1:0]   d1_out_src;
  logic         d1_out_valid;
  logic         d1_out_ready = 1'b0;

  logic [95:0]  d2_in_data = '0;
  logic [2:0]   d2_in_valid = '0;
  logic [2:0]   d2_in_ready;
  logic [1:0]   d2_sel = '0;
  logic [31:0]  d2_out_data;
  logic [1:0]   d2_out_src;
  logic         d2_out_valid;
  logic         d2_out_ready = 1'b0;

  logic [159:0] d3_in_data = '0;
  logic [4:0]   d3_in_valid = '0;
  logic [4:0]   d3_in_ready;
  logic [2:0]   d3_sel = '0;
  logic [31:0]  d3_out_data;
  logic [2:0]   d3_out_src;
  logic         d3_out_valid;
  logic         d3_out_ready = 1'b0;

  stream_mux_rr #(.WIDTH(32), .N(4), .MODE(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data), .out_src(d0_out_src),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready));

  stream_mux_rr #(.WIDTH(32), .N(4), .MODE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data), .out_src(d1_out_src),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready));

  stream_mux_rr #(.WIDTH(32), .N(3), .MODE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data), .out_src(d2_out_src),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready));

  stream_mux_rr #(.WIDTH(32), .N(5), .MODE(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .sel(d3_sel), .out_data(d3_out_data), .out_src(d3_out_src),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready));

  logic        ov   [4];
  logic        ordy [4];
  logic [31:0] od   [4];
  logic [3:0]  os   [4];
  logic [15:0] ir   [4];

  assign ov[0] = d0_out_valid;  assign ordy[0] = d0_out_ready;
  assign ov[1] = d1_out_valid;  assign ordy[1] = d1_out_ready;
  assign ov[2] = d2_out_valid;  assign ordy[2] = d2_out_ready;
  assign ov[3] = d3_out_valid;  assign ordy[3] = d3_out_ready;
  assign od[0] = d0_out_data;   assign os[0] = {2'b0, d0_out_src};
  assign od[1] = d1_out_data;   assign os[1] = {2'b0, d1_out_src};
  assign od[2] = d2_out_data;   assign os[2] = {2'b0, d2_out_src};
  assign od[3] = d3_out_data;   assign os[3] = {1'b0, d3_out_src};
  assign ir[0] = {12'b0, d0_in_ready};
  assign ir[1] = {12'b0, d1_in_ready};
  assign ir[2] = {13'b0, d2_in_ready};
  assign ir[3] = {11'b0, d3_in_ready};

  int total = 0;
  int bad = 0;

  // expected beats per DUT: {src[3:0], data[31:0]}
  logic [35:0] exp_q [4][$];
  logic [35:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int src, input logic [31:0] data);
    exp_q[d].push_back({4'(src), data});
  endtask

  task automatic flush();
    for (int d = 0; d < 4; d++) exp_q[d].delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares every beat the consumer accepts
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("onehot0_in_ready_dut%0d", d), 64'($onehot0(ir[d])), 64'd1);
        if (ov[d] && ordy[d]) begin
          if (exp_q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat_dut%0d: got src=%0h data=%0h want none", d, os[d], od[d]);
          end else begin
            mon_e = exp_q[d].pop_front();
            check($sformatf("out_data_dut%0d", d), 64'(od[d]), 64'(mon_e[31:0]));
            check($sformatf("out_src_dut%0d", d), 64'(os[d]), 64'(mon_e[35:32]));
          end
        end
      end
    end
  end

  // Round-robin stress model state (dut1)
  int          m_ptr;
  logic        m_ov;
  logic [3:0]  pending;
  logic [3:0]  hs;
  logic [3:0]  prev_v;
  logic [3:0]  prev_hs;
  logic [3:0]  exp_g;
  logic        m_found;
  int          m_c;
  logic [15:0] seq [4];

  // Round-robin directed table: valid pattern and hand-computed grant
  logic [3:0] t4_v [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 4'hF};
  logic [3:0] t4_g [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h8, 4'h1};
  int         t4_s [7] = '{0, 1, 2, 3, 0, 3, 0};
  logic [2:0] t5_g [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
  int         t5_s [4] = '{0, 2, 0, 2};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_d0_out_valid", d0_out_valid, 0);
    check("rst_d0_out_data", d0_out_data, 0);
    check("rst_d0_out_src", d0_out_src, 0);
    check("rst_d1_out_valid", d1_out_valid, 0);
    check("rst_d0_in_ready", d0_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Select path, plus out-of-range select on the N=5 instance
    d0_sel = 2'd2;
    d0_in_data[2*32 +: 32] = 32'hDEADBEEF;
    d0_in_valid = 4'b0100;
    d0_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) d3_in_data[i*32 +: 32] = 32'h5000_0000 + i;
    d3_sel = 3'd5;
    d3_in_valid = 5'b11111;
    d3_out_ready = 1'b1;
    #1;
    check("sel2_in_ready", d0_in_ready, 4'b0100);
    check("sel5_in_ready", d3_in_ready, 0);
    push(0, 2, 32'hDEADBEEF);
    tick();
    check("sel2_latency_out_valid", d0_out_valid, 1);
    d0_in_valid = 4'b0000;
    d3_sel = 3'd4;
    #1;
    check("sel4_in_ready", d3_in_ready, 5'b10000);
    push(3, 4, 32'h5000_0004);
    tick();
    d3_in_valid = 5'b00000;
    check("drain_out_valid", d0_out_valid, 0);
    check("drain_hold_data", d0_out_data, 32'hDEADBEEF);
    check("drain_hold_src", d0_out_src, 2);
    check("sel4_out_valid", d3_out_valid, 1);
    tick();
    tick();

    // Backpressure then back-to-back beats
    d0_out_ready = 1'b0;
    d0_sel = 2'd1;
    d0_in_data[1*32 +: 32] = 32'hA1A1_0001;
    d0_in_valid = 4'b0010;
    #1;
    check("bp_first_in_ready", d0_in_ready, 4'b0010);
    push(0, 1, 32'hA1A1_0001);
    tick();
    d0_in_data[1*32 +: 32] = 32'hA1A1_0002;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall_in_ready_%0d", k), d0_in_ready, 0);
      check($sformatf("bp_stall_out_data_%0d", k), d0_out_data, 32'hA1A1_0001);
      check($sformatf("bp_stall_out_valid_%0d", k), d0_out_valid, 1);
      tick();
    end
    d0_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", d0_in_ready, 4'b0010);
    push(0, 1, 32'hA1A1_0002);
    tick();
    check("b2b_out_valid_a2", d0_out_valid, 1);
    check("b2b_out_data_a2", d0_out_data, 32'hA1A1_0002);
    d0_in_data[1*32 +: 32] = 32'hA1A1_0003;
    #1;
    check("b2b_in_ready_a3", d0_in_ready, 4'b0010);
    push(0, 1, 32'hA1A1_0003);
    tick();
    check("b2b_out_valid_a3", d0_out_valid, 1);
    check("b2b_out_data_a3", d0_out_data, 32'hA1A1_0003);
    d0_in_valid = 4'b0000;
    tick();
    check("bp_end_out_valid", d0_out_valid, 0);

    // Round-robin fairness and wrap on N=4
    for (int i = 0; i < 4; i++) d1_in_data[i*32 +: 32] = 32'h1100_0000 + i;
    d1_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      d1_in_valid = t4_v[k];
      #1;
      check($sformatf("rr4_grant_%0d", k), d1_in_ready, t4_g[k]);
      push(1, t4_s[k], 32'h1100_0000 + t4_s[k]);
      tick();
    end
    d1_in_valid = 4'b0000;
    tick();
    tick();

    // Round-robin on non-power-of-2 N=3 with channels 0 and 2 valid
    for (int i = 0; i < 3; i++) d2_in_data[i*32 +: 32] = 32'h3300_0000 + i;
    d2_out_ready = 1'b1;
    d2_in_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr3_grant_%0d", k), d2_in_ready, t5_g[k]);
      push(2, t5_s[k], 32'h3300_0000 + t5_s[k]);
      tick();
    end
    d2_in_valid = 3'b000;
    tick();
    tick();

    // Reset asserted while dut0 is stalled; dut1 pointer is non-zero beforehand
    d0_out_ready = 1'b0;
    d0_sel = 2'd0;
    d0_in_data[31:0] = 32'h0BAD_0000;
    d0_in_valid = 4'b0001;
    #1;
    check("rst_pre_in_ready", d0_in_ready, 4'b0001);
    tick();
    check("rst_pre_out_valid", d0_out_valid, 1);
    #1;
    rst_n = 1'b0;
    flush();
    d1_in_valid = 4'b1111;
    #1;
    check("rst_mid_out_valid", d0_out_valid, 0);
    check("rst_mid_out_data", d0_out_data, 0);
    check("rst_mid_out_src", d0_out_src, 0);
    check("rst_mid_d0_in_ready", d0_in_ready, 0);
    check("rst_mid_d1_in_ready", d1_in_ready, 0);
    d0_in_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    check("rst_ptr_zero_grant", d1_in_ready, 4'b0001);
    push(1, 0, 32'h1100_0000);
    tick();
    d1_in_valid = 4'b0000;
    tick();
    tick();

    // Random stress on dut1 against a round-robin model
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_ptr = 0;
    m_ov = 1'b0;
    pending = '0;
    hs = '0;
    prev_v = '0;
    prev_hs = '0;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          pending[i] = 1'b0;
          seq[i] = seq[i] + 16'd1;
        end
        if (!pending[i] && ($urandom_range(0, 1) == 1)) pending[i] = 1'b1;
        d1_in_data[i*32 +: 32] = {4'(i), 12'h0, seq[i]};
      end
      d1_in_valid = pending;
      d1_out_ready = ($urandom_range(0, 3) != 0);
      #2;
      check("stress_valid_contract", 64'((prev_v & ~prev_hs) & ~d1_in_valid), 0);
      check("stress_out_valid", d1_out_valid, m_ov);
      exp_g = '0;
      m_found = 1'b0;
      m_c = 0;
      if (!m_ov || d1_out_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_found && d1_in_valid[(m_ptr + k) % 4]) begin
            m_found = 1'b1;
            m_c = (m_ptr + k) % 4;
            exp_g[m_c] = 1'b1;
          end
        end
      end
      check("stress_in_ready", d1_in_ready, exp_g);
      hs = exp_g;
      prev_v = d1_in_valid;
      prev_hs = exp_g;
      if (m_found) begin
        push(1, m_c, d1_in_data[m_c*32 +: 32]);
        m_ov = 1'b1;
        m_ptr = (m_c + 1) % 4;
      end else if (d1_out_ready) begin
        m_ov = 1'b0;
      end
    end
    tick();
    d1_in_valid = 4'b0000;
    d1_out_ready = 1'b1;
    repeat (3) tick();

    for (int d = 0; d < 4; d++) begin
      check($sformatf("queue_empty_dut%0d", d), 64'(exp_q[d].size()), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
